uart_tx_unit: RTL and testbench

Byte-wide UART transmitter sitting directly downstream of the load/store memory unit. Consumes the `data_to_uart` / `load_uart` / `transfer_byte` strobes that the memory unit raises on UART-mapped stores, and serialises the byte onto the `tx` pin as 8N1 (optionally 8E1). Returns `uart_busy` and `uart_done` to the memory unit for software-visible status polling.

---
 rtl/uart_tx_if.sv | 20 ++
 rtl/uart_tx_unit.sv | 138 +++++++++++++
 tb/tb_uart_tx_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-transfer strobes and status between the load/store memory unit and the UART transmitter.
// The memory unit drives the master side; the transmitter takes the slave side.
interface uart_tx_if;
   logic [7:0] data_to_uart;
   logic       load_uart;
   logic       transfer_byte;
   logic       tx;
   logic       uart_busy;
   logic       uart_done;

   modport master (
      output data_to_uart, load_uart, transfer_byte,
      input  tx, uart_busy, uart_done
   );

   modport slave (
      input  data_to_uart, load_uart, transfer_byte,
      output tx, uart_busy, uart_done
   );
endinterface

// File: rtl/uart_tx_unit.sv
// Byte-wide UART transmitter (8N1). Defining UART_TX_PARITY_EN inserts an even parity
// bit after data bit 7, giving an 8E1 frame.
module uart_tx_unit #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_tx_if.slave bus
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sh_q, sh_d;
   logic [7:0]       hold_q, hold_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   assign bit_end = (cnt_q == LAST_CNT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      hold_d  = bus.load_uart ? bus.data_to_uart : hold_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.transfer_byte) begin
               // A load in the same cycle bypasses the holding register.
               sh_d    = bus.load_uart ? bus.data_to_uart : hold_q;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_START;
`ifdef UART_TX_PARITY_EN
               par_d   = ^sh_d;
`endif
            end
         end
         S_START: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            if (bit_end) begin
               sh_d = {1'b0, sh_q[7:1]};
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            if (bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered yet aligned with it.
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         hold_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         hold_q  <= hold_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.tx        = tx_q;
   assign bus.uart_busy = busy_q;
   assign bus.uart_done = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Scoreboard bench for uart_tx_unit: stimulus queues expected bytes, a monitor decodes
// every frame on tx/uart_busy/uart_done against the serial line rules.
module tb_uart_tx_unit;
   localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PARITY = 1'b1;
`else
   localparam bit PARITY = 1'b0;
`endif
   localparam int FRAME_BITS = PARITY ? 11 : 10;
   localparam int FRAME      = FRAME_BITS * CLKS;

   logic clk;
   logic rst_n;
   uart_tx_if bus ();

   uart_tx_unit #(.CLKS_PER_BIT(CLKS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb_q[$];
   logic [7:0] hold_m    = 8'h00;
   bit         active_m  = 1'b0;
   longint     start_m   = 0;
   longint     model_cycle = 0;

   function automatic void check_output(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
      end
   endfunction

   // Expected line level for bit period k of a frame carrying byte b.
   function automatic logic line_level(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return ((b >> (k - 1)) & 8'd1) != 8'd0;
      if (PARITY && k == 9) return ($countones(b) % 2) == 1;
      return 1'b1;
   endfunction

   task automatic apply_stimulus(input logic ld, input logic [7:0] d, input logic tr);
      logic [7:0] sent;
      bus.load_uart     = ld;
      bus.data_to_uart  = d;
      bus.transfer_byte = tr;
      @(posedge clk);
      model_cycle++;
      if (rst_n) begin
         sent = ld ? d : hold_m;
         if (tr && (!active_m || model_cycle > start_m + FRAME)) begin
            sb_q.push_back(sent);
            start_m  = model_cycle;
            active_m = 1'b1;
         end
         if (ld) hold_m = d;
      end
      #1;
      bus.load_uart     = 1'b0;
      bus.transfer_byte = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) apply_stimulus(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic reset_pulse(input int hold_cycles);
      #2 rst_n = 1'b0;
      #1;
      check_output("async_reset_tx", bus.tx, 1'b1);
      check_output("async_reset_busy", bus.uart_busy, 1'b0);
      check_output("async_reset_done", bus.uart_done, 1'b0);
      sb_q.delete();
      active_m = 1'b0;
      hold_m   = 8'h00;
      repeat (hold_cycles) apply_stimulus(1'($urandom), 8'($urandom), 1'($urandom));
      rst_n = 1'b1;
   endtask

   bit         in_frame = 1'b0;
   int         fcyc     = 0;
   logic [7:0] fbyte    = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame = 1'b0;
         check_output("reset_tx", bus.tx, 1'b1);
         check_output("reset_busy", bus.uart_busy, 1'b0);
         check_output("reset_done", bus.uart_done, 1'b0);
      end else begin
         if (!in_frame && bus.uart_busy) begin
            check_output("frame_expected", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
               fbyte    = sb_q.pop_front();
               in_frame = 1'b1;
               fcyc     = 0;
            end
         end
         if (in_frame) begin
            if (fcyc < FRAME) begin
               check_output($sformatf("frame_%02h_bit%0d_tx", fbyte, fcyc / CLKS), bus.tx,
                            line_level(fbyte, fcyc / CLKS));
               check_output("frame_busy", bus.uart_busy, 1'b1);
               check_output("frame_done_early", bus.uart_done, 1'b0);
               fcyc++;
            end else begin
               check_output("end_done", bus.uart_done, 1'b1);
               check_output("end_busy", bus.uart_busy, 1'b0);
               check_output("end_tx", bus.tx, 1'b1);
               in_frame = 1'b0;
            end
         end else begin
            check_output("idle_done", bus.uart_done, 1'b0);
            check_output("idle_tx", bus.tx, 1'b1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n             = 1'b0;
      bus.load_uart     = 1'b0;
      bus.transfer_byte = 1'b0;
      bus.data_to_uart  = 8'h00;
      repeat (5) apply_stimulus(1'($urandom), 8'($urandom), 1'($urandom));
      rst_n = 1'b1;
      idle_cycles(3);

      // Basic frame from the holding register.
      apply_stimulus(1'b1, 8'hA5, 1'b0);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      idle_cycles(FRAME + 4);
      apply_stimulus(1'b1, 8'h07, 1'b1);
      idle_cycles(FRAME + 4);

      // Load during a frame must not disturb the byte in flight.
      apply_stimulus(1'b1, 8'h55, 1'b1);
      idle_cycles(10);
      apply_stimulus(1'b1, 8'h3C, 1'b0);
      idle_cycles(FRAME);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      idle_cycles(FRAME + 4);

      // Mid-frame start is ignored; start on the STOP edge is ignored, on the done cycle accepted.
      apply_stimulus(1'b1, 8'h81, 1'b1);
      idle_cycles(13);
      apply_stimulus(1'b1, 8'hE7, 1'b1);
      idle_cycles(FRAME - 15);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      idle_cycles(FRAME + 4);

      // Reset asserted during data bit 3 of 0xFF, then a clean 0x00 frame.
      apply_stimulus(1'b1, 8'hFF, 1'b1);
      idle_cycles(4 * CLKS + 1);
      reset_pulse(3);
      idle_cycles(FRAME + 4);
      apply_stimulus(1'b1, 8'h00, 1'b1);
      idle_cycles(FRAME + 4);

      for (int i = 0; i < 2500; i++) begin
         apply_stimulus(($urandom % 6) == 0, 8'($urandom), ($urandom % 12) == 0);
      end
      idle_cycles(FRAME + 8);
      check_output("scoreboard_drained", sb_q.size() == 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
